// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end for the pipelined RV32I core.
// Owns the PC, issues in-order requests to a variable-latency instruction
// memory, queues returned words with their PCs, and presents {pc, inst} to
// decode over a valid/ready handshake. A redirect flushes the queue and
// arranges for every response still in flight to be discarded.
module fetch_unit #(
  parameter int unsigned         XLEN       = 32,
  parameter logic [XLEN-1:0]     RESET_PC   = '0,
  parameter int unsigned         FIFO_DEPTH = 4,
  parameter int unsigned         MAX_OUTS   = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_inst
);

  localparam int unsigned OUTS_W = $clog2(MAX_OUTS + 1);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);

  localparam logic [OUTS_W-1:0] MAX_OUTS_V = OUTS_W'(MAX_OUTS);
  localparam logic [CNT_W:0]    DEPTH_V    = (CNT_W + 1)'(FIFO_DEPTH);

  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   rsp_pc;
  logic [XLEN-1:0]   pc_mem   [FIFO_DEPTH];
  logic [XLEN-1:0]   inst_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [OUTS_W-1:0] outs;
  logic [OUTS_W-1:0] drop;

  logic [CNT_W:0]    inflight;
  logic [XLEN-1:0]   redirect_base;
  logic              req_fire;
  logic              rsp_fire;
  logic              push;
  logic              pop;

  // Request credit, handshake qualification and queue port decode.
  always_comb begin
    inflight       = (CNT_W + 1)'(outs) + (CNT_W + 1)'(count);
    redirect_base  = redirect_pc & ~XLEN'(3);
    imem_req_valid = !reset && !redirect_valid && (outs < MAX_OUTS_V)
                     && (inflight < DEPTH_V);
    imem_addr      = pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is stray and never counted.
    rsp_fire       = !reset && imem_rsp_valid && (outs != '0);
    push           = rsp_fire && (drop == '0) && !redirect_valid;
    if_valid       = !reset && (count != '0);
    pop            = if_valid && if_ready && !redirect_valid;
    if_pc          = pc_mem[rd_ptr];
    if_inst        = inst_mem[rd_ptr];
  end

  // Fetch queue storage; only the tail entry is written on a push.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= rsp_pc;
      inst_mem[wr_ptr] <= imem_rsp_data;
    end
  end

  // PC, response PC, queue pointers and outstanding/drop bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      rsp_pc <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      outs   <= '0;
      drop   <= '0;
    end else if (redirect_valid) begin
      // No request can fire during a redirect, so every request still in
      // flight after this edge belongs to the old stream and is dropped.
      pc_q   <= redirect_base;
      rsp_pc <= redirect_base;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      outs   <= outs - OUTS_W'(rsp_fire);
      drop   <= outs - OUTS_W'(rsp_fire);
    end else begin
      if (req_fire) begin
        pc_q <= pc_q + XLEN'(4);
      end
      if (rsp_fire && (drop != '0)) begin
        drop <= drop - OUTS_W'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        rsp_pc <= rsp_pc + XLEN'(4);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
      outs  <= outs + OUTS_W'(req_fire) - OUTS_W'(rsp_fire);
    end
  end

endmodule
